bank_linefill_mshr: RTL and testbench

- Miss-status holding register (MSHR) for one cache bank. It sits beside the bank issue queue, between the tag-lookup stage and the BIU.
- Accepts linefill allocations from lookup and issues one read request per cacheline to the BIU.
- Tracks read-data beats and emits a one-cycle completion pulse (rvalid/rid) to the issue queue, which wakes the waiting requests.
- Supplies the combinational "cacheline inflight" query used by lookup to qualify new requests.

---
 rtl/bank_linefill_mshr.sv | 170 +++++++++++++++++
 tb/tb_bank_linefill_mshr.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_linefill_mshr.sv
// Linefill MSHR for one cache bank: tracks outstanding cacheline reads to the BIU,
// merges duplicate misses, and pulses a completion to the issue queue per line.
module bank_linefill_mshr #(
  parameter int ENTRIES  = 4,
  parameter int ID_WIDTH = 6,
  parameter int BEATS    = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         alloc_valid_i,
  input  logic [ID_WIDTH-1:0]          alloc_set_way_i,
  output logic                         alloc_ready_o,
  input  logic [ID_WIDTH-1:0]          query_set_way_i,
  output logic                         query_inflight_o,
  output logic                         biu_ar_valid_o,
  input  logic                         biu_ar_ready_i,
  output logic [ID_WIDTH-1:0]          biu_ar_id_o,
  input  logic                         biu_r_valid_i,
  input  logic [ID_WIDTH-1:0]          biu_r_id_i,
  input  logic                         biu_r_last_i,
  output logic                         biu_isu_rvalid_o,
  output logic [ID_WIDTH-1:0]          biu_isu_rid_o,
  output logic                         err_unexp_rid_o,
  output logic [$clog2(ENTRIES):0]     free_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam int FC_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e              state_q   [ENTRIES];
  state_e              state_d   [ENTRIES];
  logic [ID_WIDTH-1:0] set_way_q [ENTRIES];
  logic [ID_WIDTH-1:0] set_way_d [ENTRIES];
  logic [CNT_W-1:0]    beat_q    [ENTRIES];
  logic [CNT_W-1:0]    beat_d    [ENTRIES];

  logic [FC_W-1:0]     free_cnt_q, free_cnt_d;
  logic [IDX_W-1:0]    ar_sel_q, ar_sel_d, ar_sel;
  logic                ar_lock_q, ar_lock_d;
  logic                rvalid_q, rvalid_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic                err_q, err_d;

  logic [IDX_W-1:0]    free_idx, req_idx, r_idx;
  logic                free_found, req_found, r_hit, merge_hit;
  logic                ar_fire, alloc_new;

  // Per-entry lookups on registered state; each search keeps the lowest index.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned and infers a latch.
    merge_hit        = 1'b0;
    query_inflight_o = 1'b0;
    free_found       = 1'b0;
    free_idx         = '0;
    req_found        = 1'b0;
    req_idx          = '0;
    r_hit            = 1'b0;
    r_idx            = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (state_q[i] != ST_FREE) begin
        if (set_way_q[i] == query_set_way_i) query_inflight_o = 1'b1;
        // An entry retiring this cycle cannot absorb a merge.
        if (set_way_q[i] == alloc_set_way_i &&
            !(state_q[i] == ST_WAIT && biu_r_valid_i && biu_r_last_i &&
              biu_r_id_i == set_way_q[i]))
          merge_hit = 1'b1;
      end
      if (!free_found && state_q[i] == ST_FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (!req_found && state_q[i] == ST_REQ) begin
        req_found = 1'b1;
        req_idx   = IDX_W'(i);
      end
      if (!r_hit && biu_r_valid_i && state_q[i] == ST_WAIT &&
          set_way_q[i] == biu_r_id_i) begin
        r_hit = 1'b1;
        r_idx = IDX_W'(i);
      end
    end
  end

  // A request stalled by the BIU keeps its slot until accepted.
  assign ar_sel         = ar_lock_q ? ar_sel_q : req_idx;
  assign biu_ar_valid_o = req_found;
  assign biu_ar_id_o    = req_found ? set_way_q[ar_sel] : '0;
  assign ar_fire        = req_found & biu_ar_ready_i;
  assign alloc_new      = alloc_valid_i & ~merge_hit & free_found;
  assign alloc_ready_o  = merge_hit | (free_cnt_q != '0);

  always_comb begin
    // NOTE: next-state logic uses blocking assignments so later lines see earlier
    // ones; only the always_ff below uses non-blocking.
    for (int i = 0; i < ENTRIES; i++) begin
      state_d[i]   = state_q[i];
      set_way_d[i] = set_way_q[i];
      beat_d[i]    = beat_q[i];
    end
    if (alloc_new) begin
      state_d[free_idx]   = ST_REQ;
      set_way_d[free_idx] = alloc_set_way_i;
      beat_d[free_idx]    = '0;
    end
    if (ar_fire) begin
      state_d[ar_sel] = ST_WAIT;
      beat_d[ar_sel]  = '0;
    end
    if (r_hit) begin
      if (biu_r_last_i) state_d[r_idx] = ST_FREE;
      else              beat_d[r_idx]  = beat_q[r_idx] + CNT_W'(1);
    end

    rvalid_d = r_hit & biu_r_last_i;
    rid_d    = rvalid_d ? biu_r_id_i : '0;
    err_d    = biu_r_valid_i &
               (~r_hit | (biu_r_last_i & (beat_q[r_idx] != CNT_W'(BEATS - 1))));

    ar_lock_d = req_found & ~biu_ar_ready_i;
    ar_sel_d  = ar_sel;

    free_cnt_d = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (state_d[i] == ST_FREE) free_cnt_d = free_cnt_d + FC_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the entry arrays are a handful of flops, not RAM, so they are
      // reset outright; this also makes biu_ar_id_o well defined after reset.
      for (int i = 0; i < ENTRIES; i++) begin
        state_q[i]   <= ST_FREE;
        set_way_q[i] <= '0;
        beat_q[i]    <= '0;
      end
      free_cnt_q <= FC_W'(ENTRIES);
      ar_sel_q   <= '0;
      ar_lock_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rid_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_q[i]   <= state_d[i];
        set_way_q[i] <= set_way_d[i];
        beat_q[i]    <= beat_d[i];
      end
      free_cnt_q <= free_cnt_d;
      ar_sel_q   <= ar_sel_d;
      ar_lock_q  <= ar_lock_d;
      rvalid_q   <= rvalid_d;
      rid_q      <= rid_d;
      err_q      <= err_d;
    end
  end

  assign biu_isu_rvalid_o = rvalid_q;
  assign biu_isu_rid_o    = rid_q;
  assign err_unexp_rid_o  = err_q;
  assign free_cnt_o       = free_cnt_q;

endmodule

// File: tb/tb_bank_linefill_mshr.sv
// Directed bench for bank_linefill_mshr: a slot-level scoreboard predicts every
// output each cycle, and literal expectations pin the scenarios.
module tb_bank_linefill_mshr;

  localparam int N   = 4;
  localparam int IDW = 6;
  localparam int NB  = 2;
  localparam int P_IDLE = 0;
  localparam int P_ASK  = 1;
  localparam int P_RECV = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           alloc_valid = 1'b0;
  logic [IDW-1:0] alloc_set_way = '0;
  logic           alloc_ready;
  logic [IDW-1:0] query_set_way = '0;
  logic           query_inflight;
  logic           ar_valid;
  logic           ar_ready = 1'b0;
  logic [IDW-1:0] ar_id;
  logic           r_valid = 1'b0;
  logic [IDW-1:0] r_id = '0;
  logic           r_last = 1'b0;
  logic           isu_rvalid;
  logic [IDW-1:0] isu_rid;
  logic           err_unexp;
  logic [2:0]     free_cnt;

  int errors = 0;
  int checks = 0;

  bank_linefill_mshr #(.ENTRIES(N), .ID_WIDTH(IDW), .BEATS(NB)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .alloc_valid_i    (alloc_valid),
    .alloc_set_way_i  (alloc_set_way),
    .alloc_ready_o    (alloc_ready),
    .query_set_way_i  (query_set_way),
    .query_inflight_o (query_inflight),
    .biu_ar_valid_o   (ar_valid),
    .biu_ar_ready_i   (ar_ready),
    .biu_ar_id_o      (ar_id),
    .biu_r_valid_i    (r_valid),
    .biu_r_id_i       (r_id),
    .biu_r_last_i     (r_last),
    .biu_isu_rvalid_o (isu_rvalid),
    .biu_isu_rid_o    (isu_rid),
    .err_unexp_rid_o  (err_unexp),
    .free_cnt_o       (free_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard: one record per slot ----------------
  typedef struct { int phase; int id; int beats; } slot_t;
  slot_t slots [N];
  int held;
  int e_rvalid, e_rid, e_err;

  function automatic int m_free_count();
    int n = 0;
    for (int i = 0; i < N; i++) if (slots[i].phase == P_IDLE) n++;
    return n;
  endfunction

  function automatic int m_ar_slot();
    if (held >= 0) return held;
    for (int i = 0; i < N; i++) if (slots[i].phase == P_ASK) return i;
    return -1;
  endfunction

  function automatic bit m_merge();
    for (int i = 0; i < N; i++)
      if (slots[i].phase != P_IDLE && slots[i].id == int'(alloc_set_way) &&
          !(slots[i].phase == P_RECV && r_valid && r_last && slots[i].id == int'(r_id)))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_inflight();
    for (int i = 0; i < N; i++)
      if (slots[i].phase != P_IDLE && slots[i].id == int'(query_set_way)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) slots[i] = '{P_IDLE, 0, 0};
    held = -1; e_rvalid = 0; e_rid = 0; e_err = 0;
  endtask

  task automatic m_step();
    int ar, fs, rs;
    bit hs, mg;
    ar = m_ar_slot();
    hs = (ar >= 0) && ar_ready;
    mg = m_merge();
    fs = -1;
    for (int i = 0; i < N; i++) if (fs < 0 && slots[i].phase == P_IDLE) fs = i;
    rs = -1;
    if (r_valid)
      for (int i = 0; i < N; i++)
        if (slots[i].phase == P_RECV && slots[i].id == int'(r_id)) rs = i;
    e_rvalid = (rs >= 0 && r_last) ? 1 : 0;
    e_rid    = e_rvalid ? int'(r_id) : 0;
    e_err    = 0;
    if (r_valid && rs < 0) e_err = 1;
    if (rs >= 0 && r_last && slots[rs].beats != NB - 1) e_err = 1;
    held = (ar >= 0 && !ar_ready) ? ar : -1;
    if (alloc_valid && !mg && fs >= 0) slots[fs] = '{P_ASK, int'(alloc_set_way), 0};
    if (hs) begin slots[ar].phase = P_RECV; slots[ar].beats = 0; end
    if (rs >= 0) begin
      if (r_last) slots[rs].phase = P_IDLE;
      else        slots[rs].beats++;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int ar;
    ar = m_ar_slot();
    check("alloc_ready", alloc_ready, m_merge() || m_free_count() > 0);
    check("query_inflight", query_inflight, m_inflight());
    check("ar_valid", ar_valid, ar >= 0);
    if (ar >= 0) check("ar_id", ar_id, slots[ar].id);
    check("isu_rvalid", isu_rvalid, e_rvalid);
    if (e_rvalid != 0) check("isu_rid", isu_rid, e_rid);
    check("err_unexp", err_unexp, e_err);
    check("free_cnt", free_cnt, m_free_count());
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic drive(input logic av, input logic [IDW-1:0] aid, input logic rdy,
                       input logic rv, input logic [IDW-1:0] rid_v, input logic rl);
    alloc_valid = av; alloc_set_way = aid; ar_ready = rdy;
    r_valid = rv; r_id = rid_v; r_last = rl;
  endtask

  task automatic beats(input logic [IDW-1:0] id);
    drive(0, '0, 0, 1, id, 0); cyc();
    drive(0, '0, 0, 1, id, 1); cyc();
    drive(0, '0, 0, 0, '0, 0); cyc();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ar_valid"}, ar_valid, 0);
    check({tag, "_ar_id"}, ar_id, 0);
    check({tag, "_rvalid"}, isu_rvalid, 0);
    check({tag, "_rid"}, isu_rid, 0);
    check({tag, "_err"}, err_unexp, 0);
    check({tag, "_free"}, free_cnt, 4);
    check({tag, "_alloc_ready"}, alloc_ready, 1);
    check({tag, "_inflight"}, query_inflight, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset_values("reset");
    #9 rst_n = 1'b1;
    cyc();

    // Single fill
    query_set_way = 6'h15;
    drive(1, 6'h15, 1, 0, '0, 0); mid(); check("s1_alloc_ready", alloc_ready, 1); cyc();
    drive(0, '0, 1, 0, '0, 0); mid();
    check("s1_ar_valid", ar_valid, 1); check("s1_ar_id", ar_id, 6'h15);
    check("s1_inflight", query_inflight, 1); check("s1_free3", free_cnt, 3); cyc();
    drive(0, '0, 1, 1, 6'h15, 0); cyc();
    drive(0, '0, 1, 1, 6'h15, 1); mid(); check("s1_inflight_last", query_inflight, 1); cyc();
    drive(0, '0, 0, 0, '0, 0); mid();
    check("s1_rvalid", isu_rvalid, 1); check("s1_rid", isu_rid, 6'h15);
    check("s1_inflight_done", query_inflight, 0); check("s1_free4", free_cnt, 4);
    check("s1_err", err_unexp, 0); cyc();
    mid(); check("s1_rvalid_pulse", isu_rvalid, 0); cyc();

    // Merge
    query_set_way = 6'h07;
    drive(1, 6'h07, 0, 0, '0, 0); cyc();
    drive(1, 6'h07, 0, 0, '0, 0); mid(); check("s2_merge_ready", alloc_ready, 1); cyc();
    drive(0, '0, 1, 0, '0, 0); mid();
    check("s2_free3", free_cnt, 3); check("s2_ar_id", ar_id, 6'h07); cyc();
    drive(0, '0, 0, 0, '0, 0); mid();
    check("s2_single_ar", ar_valid, 0); check("s2_free3_after", free_cnt, 3); cyc();
    beats(6'h07);
    mid(); check("s2_free4", free_cnt, 4); cyc();

    // Full
    for (int i = 1; i <= 4; i++) begin
      drive(1, IDW'(i), 0, 0, '0, 0); cyc();
    end
    drive(1, 6'h30, 0, 0, '0, 0); mid();
    check("s3_free0", free_cnt, 0); check("s3_full_ready", alloc_ready, 0); cyc();
    drive(1, 6'h02, 0, 0, '0, 0); mid(); check("s3_live_ready", alloc_ready, 1); cyc();
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, 1, 0, '0, 0); cyc();
    end
    for (int i = 1; i <= 4; i++) beats(IDW'(i));
    mid(); check("s3_free4", free_cnt, 4); cyc();

    // AR hold against a lower-index newcomer
    drive(1, 6'h11, 1, 0, '0, 0); cyc();
    drive(1, 6'h12, 1, 0, '0, 0); cyc();
    drive(0, '0, 1, 0, '0, 0); cyc();
    drive(1, 6'h13, 0, 0, '0, 0); cyc();
    drive(1, 6'h14, 0, 0, '0, 0); cyc();
    drive(0, '0, 0, 1, 6'h11, 0); cyc();
    drive(0, '0, 0, 1, 6'h11, 1); cyc();
    drive(1, 6'h15, 0, 0, '0, 0); cyc();
    drive(0, '0, 0, 0, '0, 0); mid();
    check("s4_ar_valid", ar_valid, 1); check("s4_ar_hold", ar_id, 6'h13); cyc();
    drive(0, '0, 1, 0, '0, 0); mid(); check("s4_ar_hs", ar_id, 6'h13); cyc();
    drive(0, '0, 1, 0, '0, 0); mid(); check("s4_after_hold", ar_id, 6'h15); cyc();
    drive(0, '0, 1, 0, '0, 0); mid(); check("s4_last_ar", ar_id, 6'h14); cyc();
    drive(0, '0, 0, 0, '0, 0); cyc();
    beats(6'h12); beats(6'h13); beats(6'h15); beats(6'h14);
    mid(); check("s4_free4", free_cnt, 4); cyc();

    // Retire/alloc collision
    query_set_way = 6'h0A;
    drive(1, 6'h0A, 1, 0, '0, 0); cyc();
    drive(0, '0, 1, 0, '0, 0); cyc();
    drive(0, '0, 0, 1, 6'h0A, 0); cyc();
    drive(1, 6'h0A, 0, 1, 6'h0A, 1); mid();
    check("s5_ready", alloc_ready, 1); check("s5_free_before", free_cnt, 3); cyc();
    drive(0, '0, 0, 0, '0, 0); mid();
    check("s5_rvalid", isu_rvalid, 1); check("s5_rid", isu_rid, 6'h0A);
    check("s5_free_same", free_cnt, 3); check("s5_ar_valid", ar_valid, 1);
    check("s5_ar_id", ar_id, 6'h0A); check("s5_inflight", query_inflight, 1); cyc();
    drive(0, '0, 1, 0, '0, 0); cyc();
    drive(0, '0, 0, 0, '0, 0); cyc();
    beats(6'h0A);
    mid(); check("s5_free4", free_cnt, 4); cyc();

    // Unexpected id, short line, reset mid-linefill
    drive(0, '0, 0, 1, 6'h3F, 1); cyc();
    drive(0, '0, 0, 0, '0, 0); mid();
    check("s6_err", err_unexp, 1); check("s6_no_rvalid", isu_rvalid, 0); cyc();
    mid(); check("s6_err_pulse", err_unexp, 0); cyc();
    drive(1, 6'h2B, 1, 0, '0, 0); cyc();
    drive(0, '0, 1, 0, '0, 0); cyc();
    drive(0, '0, 0, 1, 6'h2B, 1); cyc();
    drive(0, '0, 0, 0, '0, 0); mid();
    check("s6_short_rvalid", isu_rvalid, 1); check("s6_short_rid", isu_rid, 6'h2B);
    check("s6_short_err", err_unexp, 1); cyc();
    query_set_way = 6'h20;
    drive(1, 6'h20, 1, 0, '0, 0); cyc();
    drive(0, '0, 1, 0, '0, 0); cyc();
    drive(0, '0, 0, 1, 6'h20, 0); cyc();
    drive(0, '0, 0, 0, '0, 0); mid();
    check("s6_pre_reset_inflight", query_inflight, 1); check("s6_pre_reset_free", free_cnt, 3);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    cyc();
    mid(); rst_n = 1'b1;
    cyc();
    drive(0, '0, 0, 1, 6'h20, 1); cyc();
    drive(0, '0, 0, 0, '0, 0); mid();
    check("s6_post_reset_err", err_unexp, 1); check("s6_post_reset_rvalid", isu_rvalid, 0); cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
